// File: rtl/mac4_accum.sv
// mac4_accum: sequential Q4.12 dot-product engine built on a 4-lane mac4, with bias preload and saturated output.
// Optional out_ovf port enabled by defining MAC4_ACCUM_OVF_EN.
module mac4 (
  input  logic [63:0] a_vec,
  input  logic [63:0] b_vec,
  output logic [15:0] sum
);
  logic signed [31:0] prod;
  logic [15:0] acc;
  always_comb begin
    acc = '0;
    prod = '0;
    for (int i = 0; i < 4; i++) begin
      prod = $signed(a_vec[16*i +: 16]) * $signed(b_vec[16*i +: 16]);
      acc = acc + 16'(prod >>> 14);
    end
    sum = acc;
  end
endmodule

module mac4_accum #(
  parameter int VEC_LEN = 64,
  parameter int ACC_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a_vec,
  input  logic [63:0] b_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
`ifdef MAC4_ACCUM_OVF_EN
  output logic        out_ovf,
`endif
  output logic        busy
);
  localparam int NBEATS = VEC_LEN / 4;
  localparam int CW = $clog2(NBEATS) + 1;
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);
  logic [1:0] state;
  logic signed [ACC_W-1:0] acc, sum_next;
  logic [CW-1:0] beat_cnt;
  logic [15:0] beat, sat_val;
  logic clip, ovf;
  mac4 u_mac4 (.a_vec(a_vec), .b_vec(b_vec), .sum(beat));
  always_comb begin
    sum_next = acc + ACC_W'($signed(beat));
    clip = (sum_next > MAXV) || (sum_next < MINV);
    sat_val = sum_next > MAXV ? 16'h7fff : sum_next < MINV ? 16'h8000 : sum_next[15:0];
  end
  assign in_ready = state == ACCUM;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      beat_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        acc <= ACC_W'($signed(bias));
        beat_cnt <= '0;
        state <= ACCUM;
      end
    end else if (state == ACCUM) begin
      if (in_valid) begin
        acc <= sum_next;
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == CW'(NBEATS - 1)) begin
          out_data <= sat_val;
          ovf <= clip;
          out_valid <= 1'b1;
          state <= DONE;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      ovf <= 1'b0;
      state <= IDLE;
    end
  end
`ifdef MAC4_ACCUM_OVF_EN
  assign out_ovf = ovf;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif
endmodule

// File: tb/tb_mac4_accum.sv
// tb_mac4_accum: randomized and directed checks of mac4_accum (VEC_LEN=8) against an arithmetic reference model.
module tb_mac4_accum;
  localparam int VEC_LEN = 8;
  localparam int ACC_W = 24;
  localparam int NB = VEC_LEN / 4;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [15:0] bias = 0;
  logic [63:0] a_vec = 0, b_vec = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] out_data;
  logic out_ovf;
  int cmp = 0, errs = 0;
  logic [63:0] ba [NB];
  logic [63:0] bb [NB];

  mac4_accum #(.VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
`ifdef MAC4_ACCUM_OVF_EN
    .out_ovf(out_ovf),
`endif
    .busy(busy)
  );
`ifndef MAC4_ACCUM_OVF_EN
  assign out_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic longint fdiv(longint p);
    longint r;
    r = ((p % 16384) + 16384) % 16384;
    return (p - r) / 16384;
  endfunction

  function automatic int beat_val(logic [63:0] a, logic [63:0] b);
    longint s = 0;
    logic [15:0] t;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] x, y;
      x = a[16*i +: 16];
      y = b[16*i +: 16];
      s += fdiv(longint'(x) * longint'(y));
    end
    t = 16'(s);
    return int'($signed(t));
  endfunction

  function automatic int model_raw(logic [15:0] bi);
    int s = int'($signed(bi));
    for (int k = 0; k < NB; k++) s += beat_val(ba[k], bb[k]);
    return s;
  endfunction

  function automatic logic [15:0] sat16(int s);
    return s > 32767 ? 16'h7fff : s < -32768 ? 16'h8000 : 16'(s);
  endfunction

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_valid = 1; a_vec = a; b_vec = b;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      errs++;
      $display("FAIL beat_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    cmp++;
    tick();
    in_valid = 0;
  endtask

  task automatic run_dot(input logic [15:0] bi, input int max_gap);
    start = 1; bias = bi;
    tick();
    start = 0;
    for (int k = 0; k < NB; k++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
      send_beat(ba[k], bb[k]);
    end
  endtask

  task automatic handshake();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic set_vec(input logic signed [15:0] a0, a1, a2, a3, input logic signed [15:0] b0, b1, b2, b3);
    for (int k = 0; k < NB; k++) begin
      ba[k] = {a3, a2, a1, a0};
      bb[k] = {b3, b2, b1, b0};
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    if ({in_ready, out_valid, busy, out_ovf} !== 4'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b required 0000", {in_ready, out_valid, busy, out_ovf});
    end
    cmp++;
    if (out_data !== 16'h0) begin errs++; $display("FAIL reset_data: got %h required 0000", out_data); end
    cmp++;
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    run_dot(16'd4096, 0);
    if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    cmp++;
    if (out_data !== 16'd24576) begin errs++; $display("FAIL basic_data: got %0d required 24576", $signed(out_data)); end
    cmp++;
    if (out_data !== sat16(model_raw(16'd4096))) begin errs++; $display("FAIL basic_model: got %h required %h", out_data, sat16(model_raw(16'd4096))); end
    cmp++;
`ifdef MAC4_ACCUM_OVF_EN
    if (out_ovf !== 1'b0) begin errs++; $display("FAIL basic_ovf: got %b required 0", out_ovf); end
    cmp++;
`endif
    handshake();
  endtask

  task automatic test_saturation();
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    run_dot(16'd16384, 0);
    if (out_data !== 16'h7fff) begin errs++; $display("FAIL sat_pos: got %h required 7fff", out_data); end
    cmp++;
`ifdef MAC4_ACCUM_OVF_EN
    if (out_ovf !== 1'b1) begin errs++; $display("FAIL sat_pos_ovf: got %b required 1", out_ovf); end
    cmp++;
`endif
    handshake();
    set_vec(-8192, -16384, 8192, -4096, 8192, 4096, 4096, 16384);
    run_dot(-16'sd16384, 0);
    if (out_data !== 16'h8000) begin errs++; $display("FAIL sat_neg: got %h required 8000", out_data); end
    cmp++;
`ifdef MAC4_ACCUM_OVF_EN
    if (out_ovf !== 1'b1) begin errs++; $display("FAIL sat_neg_ovf: got %b required 1", out_ovf); end
    cmp++;
`endif
    handshake();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    start = 1; bias = 16'd4096; tick(); start = 0;
    send_beat(ba[0], bb[0]);
    tick(); tick();
    send_beat(ba[1], bb[1]);
    repeat (5) begin
      if (out_valid !== 1'b1 || out_data !== 16'd24576 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    if (bad != 0) begin errs++; $display("FAIL hold_done: %0d bad cycles, required 0 (data=%0d)", bad, $signed(out_data)); end
    cmp++;
    handshake();
    if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL after_hs: valid=%b busy=%b required 0 0", out_valid, busy); end
    cmp++;
  endtask

  task automatic test_ignored();
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    in_valid = 1; a_vec = ba[0]; b_vec = bb[0];
    tick(); tick();
    in_valid = 0;
    if (busy !== 1'b0) begin errs++; $display("FAIL idle_beat: busy=%b required 0", busy); end
    cmp++;
    start = 1; bias = 16'd4096; tick(); start = 0;
    send_beat(ba[0], bb[0]);
    start = 1; bias = 16'd1000; tick(); start = 0;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL one_beat: out_valid=%b required 0", out_valid); end
    cmp++;
    send_beat(ba[1], bb[1]);
    start = 1; in_valid = 1; tick(); tick(); start = 0; in_valid = 0;
    if (out_data !== 16'd24576 || out_valid !== 1'b1) begin errs++; $display("FAIL ignored_data: got %0d valid=%b required 24576 1", $signed(out_data), out_valid); end
    cmp++;
    handshake();
  endtask

  task automatic test_reset_midop();
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    start = 1; bias = 16'd4096; tick(); start = 0;
    send_beat(ba[0], bb[0]);
    rst = 1; tick(); rst = 0;
    if ({in_ready, out_valid, busy} !== 3'b0) begin errs++; $display("FAIL midop_rst: got %b required 000", {in_ready, out_valid, busy}); end
    cmp++;
    bb[1] = '0;
    run_dot(16'd0, 0);
    if (out_data !== 16'd10240) begin errs++; $display("FAIL post_rst: got %0d required 10240", $signed(out_data)); end
    cmp++;
    handshake();
  endtask

  task automatic test_back_to_back();
    set_vec(8192, 16384, -8192, 4096, 8192, 4096, 4096, 16384);
    run_dot(16'd16384, 0);
    out_ready = 1; start = 1; bias = 16'd0; tick(); out_ready = 0; start = 0;
    if (busy !== 1'b0) begin errs++; $display("FAIL start_on_hs: busy=%b required 0", busy); end
    cmp++;
    set_vec(-8192, 4096, 0, 0, 4096, 8192, 0, 0);
    run_dot(16'd100, 0);
    if (out_data !== sat16(model_raw(16'd100))) begin errs++; $display("FAIL b2b: got %h required %h", out_data, sat16(model_raw(16'd100))); end
    cmp++;
    handshake();
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      logic [15:0] bi;
      int raw;
      bi = 16'($urandom);
      for (int k = 0; k < NB; k++) begin
        ba[k] = {$urandom, $urandom};
        bb[k] = {$urandom, $urandom};
      end
      raw = model_raw(bi);
      run_dot(bi, 3);
      if (out_valid !== 1'b1 || out_data !== sat16(raw)) begin
        errs++; $display("FAIL rand_%0d: got %h valid=%b required %h", t, out_data, out_valid, sat16(raw));
      end
      cmp++;
`ifdef MAC4_ACCUM_OVF_EN
      if (out_ovf !== (raw > 32767 || raw < -32768)) begin errs++; $display("FAIL rand_ovf_%0d: got %b", t, out_ovf); end
      cmp++;
`endif
      repeat ($urandom_range(3, 0)) tick();
      handshake();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_ignored();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/mac4_accum.md
Name: mac4_accum

Overview:
- Sequential dot-product engine that sits downstream of the combinational mac4 block. It instantiates one mac4 and accumulates its 16-bit Q4.12 partial sums over a full vector of VEC_LEN elements, four elements per beat.
- Bias is preloaded at the start of each dot product.
- Produces one saturated Q4.12 result per dot product.
- Used by the LSTM gate pre-activation path, i.e. W·x + b per output neuron.

Parameters:
- VEC_LEN, 64, number of elements per dot product; must be a multiple of 4 and at least 4 (one beat = 4 elements).
- ACC_W, 24, accumulator width in bits; signed Q(ACC_W-12).12; must be at least 16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new dot product; honoured only in IDLE.
- bias  input  16  signed Q4.12 bias; sampled on the cycle start is accepted.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a_vec  input  64  four signed Q2.14 weights; a0 = [15:0] … a3 = [63:48].
- b_vec  input  64  four signed Q4.12 inputs; b0 = [15:0] … b3 = [63:48].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  16  signed Q4.12 saturated result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values:
  - state = IDLE
  - acc = 0, beat_cnt = 0
  - in_ready = 0, out_valid = 0, out_data = 0, busy = 0
- rst asserted mid-operation aborts the dot product. Next cycle is IDLE with all reset values, and partial results are discarded.
- mac4 per-beat arithmetic:
  - Each product ai*bi is formed at 32 bits, Q6.26.
  - Each product is arithmetically shifted right by 14, to Q4.12.
  - The four shifted products are summed and truncated to 16 bits.
  - Example: beat (0.5·2.0, 1.0·1.0, −0.5·1.0, 0.25·4.0) = 10240.
- Accumulation: acc <= acc + sign_extend(mac4_result, ACC_W). No intermediate saturation; the wrap of ACC_W is not checked.
- Output saturation, applied when moving to DONE:
  - acc > 32767 → 32767
  - acc < −32768 → −32768
  - otherwise acc[15:0]
- Number of beats per dot product: NBEATS = VEC_LEN/4. beat_cnt has width $clog2(NBEATS)+1.
- FSM:
  - IDLE:
    - in_ready = 0.
    - On start: acc <= sign_extend(bias), beat_cnt <= 0, next state ACCUM.
  - ACCUM:
    - in_ready = 1.
    - Beat accepted on in_valid && in_ready: accumulate, beat_cnt++.
    - If the accepted beat is the last (beat_cnt == NBEATS−1): out_data <= sat(acc + beat), out_valid <= 1, next state DONE.
    - in_valid low: hold all state; gaps of any length are allowed.
  - DONE:
    - in_ready = 0, out_valid = 1, out_data held stable.
    - On out_ready: out_valid <= 0, next state IDLE.
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Minimum dot-product time: 1 (start) + NBEATS + 1 cycles.
- start asserted in ACCUM or DONE is ignored, with no effect on acc.
- start in the same cycle that DONE→IDLE occurs is ignored; start is honoured only when sampled in IDLE.
- in_valid asserted outside ACCUM is ignored; no beat is consumed.

Optional Feature:
- Macro: MAC4_ACCUM_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), reset 0.
  - out_ovf is set together with out_valid if the final saturation clipped.
  - out_ovf is held with out_data and cleared on the handshake.
- Undefined:
  - Port absent.
  - Saturation behaviour is identical.

Test Plan:
1. VEC_LEN=8, bias=4096 (1.0), two beats each a=(8192,16384,−8192,4096), b=(8192,4096,4096,16384) → out_valid one cycle after 2nd beat, out_data=24576 (6.0); with OVF_EN, out_ovf=0.
2. Saturation: VEC_LEN=8, bias=16384, two beats each giving 10240 → acc=36864 → out_data=32767; with OVF_EN, out_ovf=1. Repeat with all a negated and bias=−16384 → out_data=−32768.
3. Backpressure/gaps: in_valid toggled 1-0-0-1 over the beats; out_ready held 0 for 5 cycles → out_data stable at 24576, out_valid held, in_ready=0 throughout DONE. Result accepted on the out_ready cycle, then IDLE with busy=0.
4. Ignored controls: start pulses during ACCUM and DONE, and in_valid during IDLE/DONE → result unchanged (24576); exactly NBEATS beats consumed.
5. Reset mid-op: rst after 1 of 2 beats → next cycle in_ready=0, out_valid=0, busy=0. A new start with bias=0 and one 10240 beat plus one zero beat → 10240.
6. Back-to-back: second start the cycle after the DONE→IDLE handshake → second result correct with no residue from the first accumulation.
